bus_mem_responder: RTL and testbench

//  Target (responder) end of the shared register/memory bus used by the register

---
 rtl/bus_mem_responder.sv | 124 ++++++++++++
 tb/tb_bus_mem_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Target end of the shared register/memory bus: accepts one read/write at a time,
// waits LATENCY cycles, then answers with a one-cycle done strobe and address echo.
module bus_mem_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data,
  input  logic              read_q,
  input  logic              write_q,
  input  logic              rw_halt,
  inout  wire               is_bus_busy,
  output wire               read_dn,
  output wire               write_dn
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? CNT_W'(0) : CNT_W'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_wr_q, lat_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_req_c;
  logic              rd_req_c;
  logic              enter_done_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_idx_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // Unknown or undriven strobes never count as a request; write has priority.
  assign wr_req_c = (write_q == 1'b1);
  assign rd_req_c = (read_q == 1'b1) && !wr_req_c;

  // State register and transfer latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_wr_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_wr_q   <= lat_wr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state, latch and array-port logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_addr_d   = lat_addr_q;
    lat_data_d   = lat_data_q;
    lat_wr_d     = lat_wr_q;
    rdata_d      = rdata_q;
    enter_done_c = 1'b0;
    mem_we_c     = 1'b0;
    mem_idx_c    = lat_addr_q[IDX_W-1:0];
    mem_wdata_c  = lat_data_q;

    case (state_q)
      S_IDLE: begin
        if ((wr_req_c || rd_req_c) && !(rw_halt == 1'b1)) begin
          lat_addr_d = addr;
          lat_wr_d   = wr_req_c;
          if (wr_req_c) lat_data_d = data;
          cnt_d      = CNT_INIT;
          state_d    = (LATENCY == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_DONE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The write commits, and read data is captured, on the edge entering DONE.
    enter_done_c = (state_d == S_DONE) && (state_q != S_DONE);
    if (enter_done_c) begin
      mem_idx_c = lat_addr_d[IDX_W-1:0];
      if (lat_wr_d) begin
        mem_we_c    = rst;
        mem_wdata_c = lat_data_d;
      end else begin
        rdata_d = mem[lat_addr_d[IDX_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_idx_c] <= mem_wdata_c;
  end

  // Bus drivers: enables come straight from flops, so outputs move only on edges.
  assign addr        = (state_q == S_DONE) ? lat_addr_q : {ADDR_W{1'bz}};
  assign data        = (state_q == S_DONE && !lat_wr_q) ? rdata_q : {DATA_W{1'bz}};
  assign is_bus_busy = (state_q != S_IDLE) ? 1'b1 : 1'bz;
  assign read_dn     = (state_q == S_DONE && !lat_wr_q) ? 1'b1 : 1'bz;
  assign write_dn    = (state_q == S_DONE && lat_wr_q) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboarded random/directed bench for bus_mem_responder (LATENCY=2 main, LATENCY=0 side).
module tb_bus_mem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Main DUT (LATENCY=2)
  logic        read_q, write_q, rw_halt, tb_drv;
  logic [31:0] tb_addr, tb_data;
  wire  [31:0] addr, data;
  wire         is_bus_busy, read_dn, write_dn;

  assign addr = tb_drv ? tb_addr : 32'bz;
  assign data = tb_drv ? tb_data : 32'bz;

  bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .read_q(read_q), .write_q(write_q),
    .rw_halt(rw_halt), .is_bus_busy(is_bus_busy), .read_dn(read_dn), .write_dn(write_dn)
  );

  // Side DUT (LATENCY=0) for zero-latency and aliasing
  logic        read_q0, write_q0, tb_drv0;
  logic [31:0] tb_addr0, tb_data0;
  wire  [31:0] addr0, data0;
  wire         busy0, read_dn0, write_dn0;

  assign addr0 = tb_drv0 ? tb_addr0 : 32'bz;
  assign data0 = tb_drv0 ? tb_data0 : 32'bz;

  bus_mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .data(data0), .read_q(read_q0), .write_q(write_q0),
    .rw_halt(1'b0), .is_bus_busy(busy0), .read_dn(read_dn0), .write_dn(write_dn0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit        wr;
    bit [31:0] a;
    bit [31:0] d;
    bit        chk;
    int        cyc;
  } exp_t;

  exp_t       sb[$];
  bit [31:0]  mdl [int];

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done strobe and times each busy window.
  int busy_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (is_bus_busy === 1'b1) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        chk(busy_cnt == int'(LAT + 1), "busy_len", 32'(busy_cnt), 32'(LAT + 1));
        busy_cnt = 0;
      end
      if (read_dn === 1'b1 || write_dn === 1'b1) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_strobe", {30'd0, read_dn, write_dn}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk((write_dn === 1'b1) == e.wr && (read_dn === 1'b1) == !e.wr, "strobe_kind",
              {30'd0, read_dn, write_dn}, e.wr ? 32'd1 : 32'd2);
          chk(addr === e.a, "echo_addr", addr, e.a);
          chk(is_bus_busy === 1'b1, "busy_in_done", {31'd0, is_bus_busy}, 32'd1);
          chk(cyc == e.cyc + int'(LAT), "latency", 32'(cyc - e.cyc), 32'(LAT));
          if (!e.wr && e.chk) chk(data === e.d, "read_data", data, e.d);
        end
      end
    end
  end

  task automatic drive(input bit wr, input bit rd, input bit halt, input logic [31:0] a,
                       input logic [31:0] d);
    write_q = wr; read_q = rd; rw_halt = halt; tb_addr = a; tb_data = d; tb_drv = 1'b1;
    @(posedge clk); #1;
    write_q = 1'b0; read_q = 1'b0; rw_halt = 1'b0; tb_drv = 1'b0;
  endtask

  // Issue one request from idle; the reference decides whether it completes and with what.
  task automatic xfer(input bit wr, input bit rd, input bit halt, input logic [31:0] a,
                      input logic [31:0] d);
    exp_t e;
    int   idx;
    idx = int'(a % DEPTH);
    drive(wr, rd, halt, a, d);
    if (halt || !(wr || rd)) return;
    e.wr  = wr;
    e.a   = a;
    e.cyc = cyc;
    if (wr) begin
      e.d = d; e.chk = 1'b0; mdl[idx] = d;
    end else begin
      e.chk = mdl.exists(idx) ? 1'b1 : 1'b0;
      e.d   = e.chk ? mdl[idx] : 32'd0;
    end
    sb.push_back(e);
    repeat (LAT + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit          wr, rd, halt;
    logic [31:0] a, d;
    read_q = 0; write_q = 0; rw_halt = 0; tb_drv = 0; tb_addr = 0; tb_data = 0;
    read_q0 = 0; write_q0 = 0; tb_drv0 = 0; tb_addr0 = 0; tb_data0 = 0;

    // Reset: nothing asserted while held
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(is_bus_busy !== 1'b1 && read_dn !== 1'b1 && write_dn !== 1'b1, "reset_outputs",
          {29'd0, is_bus_busy, read_dn, write_dn}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(is_bus_busy !== 1'b1 && read_dn !== 1'b1 && write_dn !== 1'b1, "idle_outputs",
        {29'd0, is_bus_busy, read_dn, write_dn}, 32'd0);
    @(posedge clk); #1;

    // Write then read back
    xfer(1, 0, 0, 32'd5, 32'hDEADBEEF);
    xfer(0, 1, 0, 32'd5, 32'h0);

    // Halted request is dropped, retry served
    xfer(0, 1, 1, 32'd7, 32'h0);
    @(negedge clk);
    chk(is_bus_busy !== 1'b1, "halt_no_busy", {31'd0, is_bus_busy}, 32'd0);
    @(posedge clk); #1;
    xfer(1, 0, 0, 32'd7, 32'h0000_0777);
    xfer(0, 1, 0, 32'd7, 32'h0);

    // Request during WAIT is lost
    xfer(1, 0, 0, 32'd3, 32'h3333_0003);
    drive(0, 1, 0, 32'd3, 32'h0);
    begin
      exp_t e;
      e.wr = 0; e.a = 32'd3; e.d = 32'h3333_0003; e.chk = 1; e.cyc = cyc;
      sb.push_back(e);
    end
    drive(0, 1, 0, 32'd9, 32'h0);
    repeat (LAT) @(posedge clk);
    #1;

    // Read and write together: write wins
    xfer(1, 1, 0, 32'd11, 32'hA5A5_0011);
    xfer(0, 1, 0, 32'd11, 32'h0);

    // Zero latency plus aliasing on the side DUT
    write_q0 = 1; tb_addr0 = 32'h105; tb_data0 = 32'h11; tb_drv0 = 1;
    @(posedge clk); #1;
    write_q0 = 0; tb_drv0 = 0;
    @(negedge clk);
    chk(write_dn0 === 1'b1, "l0_write_dn", {31'd0, write_dn0}, 32'd1);
    chk(addr0 === 32'h105, "l0_echo_addr", addr0, 32'h105);
    chk(busy0 === 1'b1, "l0_busy", {31'd0, busy0}, 32'd1);
    @(posedge clk); #1;
    read_q0 = 1; tb_addr0 = 32'h5; tb_drv0 = 1;
    @(negedge clk);
    chk(write_dn0 !== 1'b1 && busy0 !== 1'b1, "l0_done_one_cycle", {30'd0, write_dn0, busy0}, 32'd0);
    @(posedge clk); #1;
    read_q0 = 0; tb_drv0 = 0;
    @(negedge clk);
    chk(read_dn0 === 1'b1, "l0_read_dn", {31'd0, read_dn0}, 32'd1);
    chk(data0 === 32'h11, "l0_alias_data", data0, 32'h11);
    chk(addr0 === 32'h5, "l0_read_addr", addr0, 32'h5);
    @(posedge clk); #1;

    // Randomized traffic from idle
    for (int i = 0; i < 60; i++) begin
      wr   = ($urandom_range(0, 1) == 1);
      rd   = !wr || ($urandom_range(0, 4) == 0);
      halt = ($urandom_range(0, 5) == 0);
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15));
      d    = 32'($urandom);
      xfer(wr, rd, halt, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Reset during WAIT aborts the write
    xfer(1, 0, 0, 32'd2, 32'h0);
    drive(1, 0, 0, 32'd2, 32'h55);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1, 0, 32'd2, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    chk(sb.size() == 0, "sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
